// File: rtl/mult_arb_pkg.sv
// Shared types and the multiplier slave register map for avalon_mm_mult_arbiter.
package mult_arb_pkg;

    localparam int WORD_W = 16;

    localparam logic [3:0] ADDR_A_LO = 4'd0;
    localparam logic [3:0] ADDR_A_HI = 4'd1;
    localparam logic [3:0] ADDR_B_LO = 4'd2;
    localparam logic [3:0] ADDR_B_HI = 4'd3;
    localparam logic [3:0] ADDR_RES0 = 4'd4;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WAIT,
        RD,
        CAP,
        DONE
    } state_t;

    function automatic logic [3:0] res_addr(input logic [1:0] beat);
        return ADDR_RES0 + {2'b00, beat};
    endfunction

endpackage

// File: rtl/mult_arb_select.sv
// Winner pick for the multiplier arbiter: fixed priority, or round-robin from ptr_i
// when MULT_ARB_RR_EN is defined.
module mult_arb_select
    import mult_arb_pkg::*;
#(
    parameter int  N_REQ = 2,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
`ifdef MULT_ARB_RR_EN
    input  logic [IDX_W-1:0] ptr_i,
`endif
    output logic [N_REQ-1:0] gnt_oh_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             valid_o
);

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        valid_o   = 1'b0;
`ifdef MULT_ARB_RR_EN
        // First pass covers indices at or above the pointer; the second wraps around.
        for (int i = 0; i < N_REQ; i++) begin
            if (!valid_o && req_i[i] && (IDX_W'(i) >= ptr_i)) begin
                valid_o     = 1'b1;
                gnt_oh_o[i] = 1'b1;
                gnt_idx_o   = IDX_W'(i);
            end
        end
`endif
        for (int i = 0; i < N_REQ; i++) begin
            if (!valid_o && req_i[i]) begin
                valid_o     = 1'b1;
                gnt_oh_o[i] = 1'b1;
                gnt_idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/avalon_mm_mult_arbiter.sv
// Shares one Avalon-MM 32x32 multiplier slave between N_REQ requesters.
// Define MULT_ARB_RR_EN for round-robin arbitration; fixed priority otherwise.
module avalon_mm_mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int SZ       = 32,
    parameter int N_REQ    = 2,
    parameter int WAIT_CYC = 4
) (
    input  logic                clk,
    input  logic                _rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*SZ-1:0] a_i,
    input  logic [N_REQ*SZ-1:0] b_i,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    done,
    output logic [2*SZ-1:0]     res_o,
    output logic [3:0]          addr,
    output logic                read,
    output logic                write,
    output logic [WORD_W-1:0]   write_data,
    input  logic [WORD_W-1:0]   read_data
);

    localparam int         IDX_W     = $clog2(N_REQ);
    localparam logic [7:0] WAIT_INIT = 8'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

    state_t              state_q, state_d;
    logic [1:0]          beat_q, beat_d;
    logic [7:0]          wait_q, wait_d;
    logic [SZ-1:0]       a_q, a_d, b_q, b_d;
    logic [2*SZ-1:0]     res_q, res_d;
    logic [N_REQ-1:0]    win_q, win_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d, done_q, done_d;
    logic [3:0]          addr_q, addr_d;
    logic                read_q, read_d, write_q, write_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                rd_vld_q, rd_vld_d;
    logic [1:0]          rd_word_q, rd_word_d;

    logic [N_REQ-1:0]    sel_oh;
    logic [IDX_W-1:0]    sel_idx;
    logic                sel_valid;
    logic [SZ-1:0]       a_arr [N_REQ];
    logic [SZ-1:0]       b_arr [N_REQ];

`ifdef MULT_ARB_RR_EN
    logic [IDX_W-1:0]    ptr_q, ptr_d;
`endif

    mult_arb_select #(
        .N_REQ     (N_REQ)
    ) u_select (
        .req_i     (req),
`ifdef MULT_ARB_RR_EN
        .ptr_i     (ptr_q),
`endif
        .gnt_oh_o  (sel_oh),
        .gnt_idx_o (sel_idx),
        .valid_o   (sel_valid)
    );

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            a_arr[k] = a_i[k*SZ +: SZ];
            b_arr[k] = b_i[k*SZ +: SZ];
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        wait_d    = wait_q;
        a_d       = a_q;
        b_d       = b_q;
        win_d     = win_q;
        res_d     = res_q;
        gnt_d     = '0;
        done_d    = '0;
        addr_d    = '0;
        read_d    = 1'b0;
        write_d   = 1'b0;
        wdata_d   = '0;
        // The slave registers its read data, so capture trails each read by one cycle.
        rd_vld_d  = read_q;
        rd_word_d = addr_q[1:0];
`ifdef MULT_ARB_RR_EN
        ptr_d     = ptr_q;
`endif

        if (rd_vld_q) begin
            for (int w = 0; w < 4; w++) begin
                if (rd_word_q == 2'(w)) res_d[w*WORD_W +: WORD_W] = read_data;
            end
        end

        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    gnt_d   = sel_oh;
                    win_d   = sel_oh;
                    a_d     = a_arr[sel_idx];
                    b_d     = b_arr[sel_idx];
                    beat_d  = '0;
                    state_d = WR;
`ifdef MULT_ARB_RR_EN
                    ptr_d   = (sel_idx == IDX_W'(N_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
`endif
                end
            end
            WR: begin
                write_d = 1'b1;
                beat_d  = beat_q + 2'd1;
                case (beat_q)
                    2'd0:    begin addr_d = ADDR_A_LO; wdata_d = a_q[0 +: WORD_W];      end
                    2'd1:    begin addr_d = ADDR_A_HI; wdata_d = a_q[WORD_W +: WORD_W]; end
                    2'd2:    begin addr_d = ADDR_B_LO; wdata_d = b_q[0 +: WORD_W];      end
                    default: begin addr_d = ADDR_B_HI; wdata_d = b_q[WORD_W +: WORD_W]; end
                endcase
                if (beat_q == 2'd3) begin
                    if (WAIT_CYC == 0) begin
                        state_d = RD;
                    end else begin
                        state_d = WAIT;
                        wait_d  = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                wait_d = wait_q - 8'd1;
                if (wait_q == 8'd0) state_d = RD;
            end
            RD: begin
                read_d = 1'b1;
                addr_d = res_addr(beat_q);
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) state_d = CAP;
            end
            CAP: begin
                // Two quiet cycles let the last two read words land in res_q.
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd1) begin
                    beat_d  = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset clears data registers too, so a reset-aborted job leaves no stale product.
        if (!_rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            wait_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            win_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            addr_q    <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            rd_vld_q  <= 1'b0;
            rd_word_q <= '0;
        end else begin
            // NOTE: non-blocking updates keep every flop sampling pre-edge values.
            state_q   <= state_d;
            beat_q    <= beat_d;
            wait_q    <= wait_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            win_q     <= win_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            addr_q    <= addr_d;
            read_q    <= read_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            rd_vld_q  <= rd_vld_d;
            rd_word_q <= rd_word_d;
        end
    end

`ifdef MULT_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (!_rst) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
`endif

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign res_o      = res_q;
    assign addr       = addr_q;
    assign read       = read_q;
    assign write      = write_q;
    assign write_data = wdata_q;

endmodule
